// File: rtl/zbt_bitstream_shifter.sv
// zbt_bitstream_shifter
//   Fetches an inclusive, optionally wrapping range of 32-bit words from ZBT
//   SRAM into an on-chip FIFO and presents an MSB-first 32-bit look-ahead
//   window that the consumer may advance by 0..32 bits per cycle.
//
// Optional feature: define ZBT_BITSTR_BYTE_ALIGN_EN to add Byte_Align_I and a
//   consumed-bit position counter (mod 8) used to discard up to the next byte
//   boundary.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   Start_I             flush and start fetching Start_Address_I..End_Address_I
//   Start_Address_I     first word address
//   End_Address_I       last word address (inclusive)
//   ZBT_Busy_I          arbiter stall, no read issued while high
//   ZBT_Read_En_O       read strobe (one word per cycle)
//   ZBT_Address_O       read address
//   ZBT_Data_I          read data, valid READ_LATENCY cycles after the strobe
//   Shift_En_I          consume Shift_Amount_I bits this cycle
//   Shift_Amount_I      bits to consume, 0..32 legal
//   Byte_Align_I        (optional) discard bits up to the next byte boundary
//   Bitstream_Data_O    top 32 bits of the window, MSB = next bit
//   Bits_Available_O    valid bits in the window, 0..64
//   Valid_O             Bits_Available_O >= 32
//   Stream_End_O        range fully fetched and consumed
//   Shift_Error_O       one-cycle pulse after a rejected request
module zbt_bitstream_shifter #(
  parameter int unsigned ADDR_WIDTH     = 19,
  parameter int unsigned BUF_ADDR_WIDTH = 4,
  parameter int unsigned READ_LATENCY   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  Start_I,
  input  logic [ADDR_WIDTH-1:0] Start_Address_I,
  input  logic [ADDR_WIDTH-1:0] End_Address_I,
  input  logic                  ZBT_Busy_I,
  output logic                  ZBT_Read_En_O,
  output logic [ADDR_WIDTH-1:0] ZBT_Address_O,
  input  logic [31:0]           ZBT_Data_I,
  input  logic                  Shift_En_I,
  input  logic [5:0]            Shift_Amount_I,
`ifdef ZBT_BITSTR_BYTE_ALIGN_EN
  input  logic                  Byte_Align_I,
`endif
  output logic [31:0]           Bitstream_Data_O,
  output logic [6:0]            Bits_Available_O,
  output logic                  Valid_O,
  output logic                  Stream_End_O,
  output logic                  Shift_Error_O
);

  localparam int unsigned DEPTH = 1 << BUF_ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE = 1;
  localparam logic [BUF_ADDR_WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [BUF_ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [BUF_ADDR_WIDTH+1:0] OCC_MAX  = DEPTH;

  // Fetch side
  logic                    r_active;
  logic                    r_end_issued;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_end;
  logic [READ_LATENCY-1:0] r_vld;
  logic [BUF_ADDR_WIDTH:0] r_inflight;

  // FIFO
  logic [31:0]               r_mem [DEPTH];
  logic [BUF_ADDR_WIDTH-1:0] r_wptr;
  logic [BUF_ADDR_WIDTH-1:0] r_rptr;
  logic [BUF_ADDR_WIDTH:0]   r_count;

  // Window
  logic [63:0] r_win;
  logic [6:0]  r_bits;
  logic        r_err;

`ifdef ZBT_BITSTR_BYTE_ALIGN_EN
  logic [2:0]  r_pos;
  logic [2:0]  w_align;
`endif

  logic [BUF_ADDR_WIDTH+1:0] w_occ;
  logic                      w_issue;
  logic                      w_arrive;
  logic [READ_LATENCY-1:0]   w_vld_nx;
  logic                      w_req;
  logic                      w_conflict;
  logic [5:0]                w_amt;
  logic                      w_accept;
  logic                      w_err;
  logic [6:0]                w_sh;
  logic [6:0]                w_bits_sh;
  logic [63:0]               w_win_sh;
  logic                      w_refill;
  logic [63:0]               w_win_nx;
  logic [6:0]                w_bits_nx;

  // FIFO count plus reads still in flight bounds issue, so arriving data
  // always finds a free slot.
  always_comb begin
    w_occ    = {1'b0, r_count} + {1'b0, r_inflight};
    w_issue  = r_active & ~reset & ~Start_I & ~r_end_issued & ~ZBT_Busy_I &
               (w_occ < OCC_MAX);
    w_arrive = r_vld[READ_LATENCY-1];
    w_vld_nx    = r_vld << 1;
    w_vld_nx[0] = w_issue;
  end

  always_comb begin
    w_req      = Shift_En_I;
    w_amt      = Shift_Amount_I;
    w_conflict = 1'b0;
`ifdef ZBT_BITSTR_BYTE_ALIGN_EN
    w_align = 3'd0 - r_pos;
    if (Byte_Align_I) begin
      w_req      = 1'b1;
      w_amt      = {3'b000, w_align};
      w_conflict = Shift_En_I;
    end
`endif
    w_accept  = w_req & ~w_conflict & ({1'b0, w_amt} <= 7'd32) &
                ({1'b0, w_amt} <= r_bits);
    w_err     = w_req & ~w_accept;
    w_sh      = w_accept ? {1'b0, w_amt} : '0;
    w_bits_sh = r_bits - w_sh;
    w_win_sh  = r_win << w_sh;
    // The FIFO head lands directly below the bits left after the shift.
    w_refill  = (w_bits_sh <= 7'd32) && (r_count != '0);
    w_win_nx  = w_win_sh;
    w_bits_nx = w_bits_sh;
    if (w_refill) begin
      w_win_nx  = w_win_sh | ({r_mem[r_rptr], 32'h0} >> w_bits_sh);
      w_bits_nx = w_bits_sh + 7'd32;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_active     <= 1'b0;
      r_end_issued <= 1'b0;
      r_addr       <= '0;
      r_end        <= '0;
      r_vld        <= '0;
      r_inflight   <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_win        <= '0;
      r_bits       <= '0;
      r_err        <= 1'b0;
`ifdef ZBT_BITSTR_BYTE_ALIGN_EN
      r_pos        <= '0;
`endif
    end else if (Start_I) begin
      r_active     <= 1'b1;
      r_end_issued <= 1'b0;
      r_addr       <= Start_Address_I;
      r_end        <= End_Address_I;
      r_vld        <= '0;
      r_inflight   <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_win        <= '0;
      r_bits       <= '0;
      r_err        <= 1'b0;
`ifdef ZBT_BITSTR_BYTE_ALIGN_EN
      r_pos        <= '0;
`endif
    end else begin
      if (w_issue) begin
        r_addr <= r_addr + ADDR_ONE;
        if (r_addr == r_end) r_end_issued <= 1'b1;
      end
      r_vld <= w_vld_nx;
      unique case ({w_issue, w_arrive})
        2'b10:   r_inflight <= r_inflight + CNT_ONE;
        2'b01:   r_inflight <= r_inflight - CNT_ONE;
        default: ;
      endcase
      if (w_arrive) r_wptr <= r_wptr + PTR_ONE;
      if (w_refill) r_rptr <= r_rptr + PTR_ONE;
      unique case ({w_arrive, w_refill})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: ;
      endcase
      r_win  <= w_win_nx;
      r_bits <= w_bits_nx;
      r_err  <= w_err;
`ifdef ZBT_BITSTR_BYTE_ALIGN_EN
      if (w_accept) r_pos <= r_pos + w_amt[2:0];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (w_arrive && !reset && !Start_I) r_mem[r_wptr] <= ZBT_Data_I;
  end

  assign ZBT_Read_En_O    = w_issue;
  assign ZBT_Address_O    = r_addr;
  assign Bitstream_Data_O = r_win[63:32];
  assign Bits_Available_O = r_bits;
  assign Valid_O          = (r_bits >= 7'd32);
  assign Stream_End_O     = r_active & r_end_issued & (r_inflight == '0) &
                            (r_count == '0) & (r_bits == '0);
  assign Shift_Error_O    = r_err;

endmodule

// File: tb/tb_zbt_bitstream_shifter.sv
// tb_zbt_bitstream_shifter
//   Self-checking bench for zbt_bitstream_shifter. A ZBT memory model answers
//   reads after READ_LATENCY cycles; a stream-level reference model predicts
//   every output each cycle from consumed-bit position and occupancy counts.
module tb_zbt_bitstream_shifter;

  localparam int AW    = 19;
  localparam int L     = 3;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          Start_I;
  logic [AW-1:0] Start_Address_I;
  logic [AW-1:0] End_Address_I;
  logic          ZBT_Busy_I;
  logic          ZBT_Read_En_O;
  logic [AW-1:0] ZBT_Address_O;
  logic [31:0]   ZBT_Data_I;
  logic          Shift_En_I;
  logic [5:0]    Shift_Amount_I;
  logic          Byte_Align_I;
  logic [31:0]   Bitstream_Data_O;
  logic [6:0]    Bits_Available_O;
  logic          Valid_O;
  logic          Stream_End_O;
  logic          Shift_Error_O;

  always #5 clock = ~clock;

  zbt_bitstream_shifter #(
    .ADDR_WIDTH    (AW),
    .BUF_ADDR_WIDTH(4),
    .READ_LATENCY  (L)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .Start_I         (Start_I),
    .Start_Address_I (Start_Address_I),
    .End_Address_I   (End_Address_I),
    .ZBT_Busy_I      (ZBT_Busy_I),
    .ZBT_Read_En_O   (ZBT_Read_En_O),
    .ZBT_Address_O   (ZBT_Address_O),
    .ZBT_Data_I      (ZBT_Data_I),
    .Shift_En_I      (Shift_En_I),
    .Shift_Amount_I  (Shift_Amount_I),
`ifdef ZBT_BITSTR_BYTE_ALIGN_EN
    .Byte_Align_I    (Byte_Align_I),
`endif
    .Bitstream_Data_O(Bitstream_Data_O),
    .Bits_Available_O(Bits_Available_O),
    .Valid_O         (Valid_O),
    .Stream_End_O    (Stream_End_O),
    .Shift_Error_O   (Shift_Error_O)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [AW-1:0] a);
    case (a)
      19'h00010: return 32'h12345678;
      19'h00011: return 32'h9ABCDEF0;
      19'h00012: return 32'h0F0F0F0F;
      19'h00013: return 32'hCAFEBABE;
      default:   return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endcase
  endfunction

  // ZBT environment: strobes travel L cycles before their data is driven.
  logic          env_v [L];
  logic [AW-1:0] env_a [L];

  // Reference model state
  bit            m_active, m_end_issued, m_err;
  logic [AW-1:0] m_addr, m_end, m_start;
  int            m_fifo_n, m_avail, m_pos;
  longint        m_cons;
  int            m_infl [$];

  int            n_reads = 0;
  logic [AW-1:0] rd_log [$];

  task automatic m_clear();
    m_end_issued = 0; m_err = 0; m_fifo_n = 0; m_avail = 0; m_pos = 0;
    m_cons = 0; m_infl = {};
  endtask

  function automatic logic [31:0] exp_data();
    logic [31:0] d;
    logic [31:0] w;
    longint      j;
    d = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < m_avail) begin
        j = m_cons + i;
        w = mem(m_start + AW'(j / 32));
        d[31-i] = w[31 - int'(j % 32)];
      end
    end
    return d;
  endfunction

  task automatic step();
    bit exp_issue, req, acc, conflict;
    int amt;
    int nq [$];
    @(negedge clock);
    exp_issue = !reset && !Start_I && m_active && !m_end_issued && !ZBT_Busy_I &&
                (m_fifo_n + m_infl.size() < DEPTH);
    chk("read_en", ZBT_Read_En_O, exp_issue);
    chk("address", ZBT_Address_O, m_addr);
    chk("data", Bitstream_Data_O, exp_data());
    chk("avail", Bits_Available_O, m_avail);
    chk("valid", Valid_O, m_avail >= 32);
    chk("stream_end", Stream_End_O,
        m_active && m_end_issued && m_infl.size() == 0 && m_fifo_n == 0 && m_avail == 0);
    chk("shift_err", Shift_Error_O, m_err);
    if (ZBT_Read_En_O) begin
      n_reads++;
      rd_log.push_back(ZBT_Address_O);
    end
    for (int i = L - 1; i > 0; i--) begin
      env_v[i] = env_v[i-1];
      env_a[i] = env_a[i-1];
    end
    env_v[0] = ZBT_Read_En_O;
    env_a[0] = ZBT_Address_O;

    if (reset) begin
      m_clear();
      m_active = 0; m_addr = '0; m_end = '0; m_start = '0;
    end else if (Start_I) begin
      m_clear();
      m_active = 1; m_addr = Start_Address_I; m_start = Start_Address_I;
      m_end = End_Address_I;
    end else begin
      req = Shift_En_I; amt = int'(Shift_Amount_I); conflict = 0;
`ifdef ZBT_BITSTR_BYTE_ALIGN_EN
      if (Byte_Align_I) begin
        req = 1; amt = (8 - m_pos) % 8; conflict = Shift_En_I;
      end
`endif
      acc = req && !conflict && amt <= 32 && amt <= m_avail;
      m_err = req && !acc;
      if (acc) begin
        m_avail -= amt; m_cons += amt; m_pos = (m_pos + amt) % 8;
      end
      if (m_avail <= 32 && m_fifo_n > 0) begin
        m_fifo_n--; m_avail += 32;
      end
      foreach (m_infl[i]) begin
        if (m_infl[i] == 1) m_fifo_n++;
        else nq.push_back(m_infl[i] - 1);
      end
      m_infl = nq;
      if (exp_issue) begin
        m_infl.push_back(L);
        if (m_addr == m_end) m_end_issued = 1;
        m_addr = m_addr + 1'b1;
      end
    end
    @(posedge clock);
    #1;
    ZBT_Data_I = env_v[L-1] ? mem(env_a[L-1]) : $urandom();
  endtask

  task automatic idle_inputs();
    Start_I = 0; Shift_En_I = 0; Shift_Amount_I = '0; ZBT_Busy_I = 0; Byte_Align_I = 0;
  endtask

  task automatic start(input logic [AW-1:0] s, input logic [AW-1:0] e);
    Start_I = 1; Start_Address_I = s; End_Address_I = e;
    step();
    Start_I = 0;
  endtask

  task automatic do_shift(input int amt);
    Shift_En_I = 1; Shift_Amount_I = 6'(amt);
    step();
    Shift_En_I = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Random legal-sized consumption until the stream ends or the budget runs out.
  task automatic drain(input int budget, input int busy_pct);
    int amt;
    for (int i = 0; i < budget; i++) begin
      if (m_active && m_end_issued && m_avail == 0 && m_fifo_n == 0 && m_infl.size() == 0)
        break;
      amt = $urandom_range(0, 32);
      if (amt > m_avail) amt = m_avail;
      Shift_En_I = 1; Shift_Amount_I = 6'(amt);
      ZBT_Busy_I = ($urandom_range(0, 99) < busy_pct);
      step();
    end
    idle_inputs();
    chk("drained_stream_end", Stream_End_O, 1'b1);
  endtask

  int r0;

  initial begin
    idle_inputs();
    reset = 1; Start_Address_I = '0; End_Address_I = '0; ZBT_Data_I = '0;
    for (int i = 0; i < L; i++) begin env_v[i] = 0; env_a[i] = '0; end
    m_clear(); m_active = 0; m_addr = '0; m_end = '0; m_start = '0;
    @(posedge clock); #1;
    step();
    reset = 0;
    chk("rst_data", Bitstream_Data_O, 32'h0);
    chk("rst_avail", Bits_Available_O, 7'd0);
    chk("rst_end", Stream_End_O, 1'b0);
    r0 = n_reads;
    idle(4);
    chk("idle_no_reads", n_reads - r0, 0);

    // Basic stream timing and first shift
    start(19'h10, 19'h13);
    idle(5);
    chk("first_valid", Valid_O, 1'b1);
    chk("first_word", Bitstream_Data_O, 32'h12345678);
    do_shift(4);
    chk("shift4", Bitstream_Data_O, 32'h23456789);

    // Variable shifts over the same data, then drain to the end
    start(19'h10, 19'h13);
    idle(10);
    do_shift(1);  chk("shift1", Bitstream_Data_O, 32'h2468ACF1);
    do_shift(7);  chk("shift7", Bitstream_Data_O, 32'h3456789A);
    do_shift(24); chk("shift24", Bitstream_Data_O, 32'h9ABCDEF0);
    do_shift(32); chk("shift32", Bitstream_Data_O, 32'h0F0F0F0F);
    drain(100, 0);
    do_shift(1);
    chk("end_shift_err", Shift_Error_O, 1'b1);

    // Backpressure: FIFO plus window bound the reads
    start(19'h100, 19'h163);
    r0 = n_reads;
    idle(40);
    chk("full_reads", n_reads - r0, 18);
    r0 = n_reads;
    ZBT_Busy_I = 1;
    for (int i = 0; i < 5; i++) do_shift(32);
    chk("busy_no_reads", n_reads - r0, 0);
    ZBT_Busy_I = 0;
    drain(600, 25);

    // Wrap across the top of the address space
    rd_log = {};
    start(19'h7FFFE, 19'h00001);
    idle(12);
    chk("wrap_count", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      chk("wrap_a0", rd_log[0], 19'h7FFFE);
      chk("wrap_a1", rd_log[1], 19'h7FFFF);
      chk("wrap_a2", rd_log[2], 19'h00000);
      chk("wrap_a3", rd_log[3], 19'h00001);
    end

    // Restart one cycle after the second read drops in-flight data
    start(19'h7FFFE, 19'h00001);
    idle(2);
    start(19'h20, 19'h22);
    for (int i = 0; i < 20 && m_avail < 32; i++) step();
    chk("restart_first", Bitstream_Data_O, mem(19'h20));
    drain(100, 10);

    // Illegal amount, then reset mid-stream
    start(19'h200, 19'h240);
    idle(12);
    do_shift(33);
    chk("amt33_err", Shift_Error_O, 1'b1);
    chk("amt33_avail", Bits_Available_O, 7'd64);
    do_shift(0);
    chk("amt0_no_err", Shift_Error_O, 1'b0);
    reset = 1;
    step();
    reset = 0;
    chk("mid_rst_data", Bitstream_Data_O, 32'h0);
    chk("mid_rst_avail", Bits_Available_O, 7'd0);
    chk("mid_rst_valid", Valid_O, 1'b0);
    chk("mid_rst_err", Shift_Error_O, 1'b0);
    r0 = n_reads;
    idle(5);
    chk("mid_rst_no_reads", n_reads - r0, 0);

`ifdef ZBT_BITSTR_BYTE_ALIGN_EN
    start(19'h10, 19'h13);
    idle(10);
    do_shift(3);
    Byte_Align_I = 1; step(); Byte_Align_I = 0;
    chk("align_avail", Bits_Available_O, 7'd56);
    chk("align_data", Bitstream_Data_O, 32'h3456789A);
    Byte_Align_I = 1; Shift_En_I = 1; Shift_Amount_I = 6'd4;
    step();
    idle_inputs();
    chk("align_conflict_err", Shift_Error_O, 1'b1);
    chk("align_conflict_avail", Bits_Available_O, 7'd56);
`endif

    // Randomized traffic with occasional restarts and illegal amounts
    for (int run = 0; run < 4; run++) begin
      logic [AW-1:0] s;
      s = (run % 2 == 0) ? AW'($urandom()) : AW'(19'h7FFF0 + $urandom_range(0, 15));
      start(s, s + AW'($urandom_range(0, 24)));
      for (int c = 0; c < 200; c++) begin
        ZBT_Busy_I = ($urandom_range(0, 99) < 30);
        Shift_En_I = ($urandom_range(0, 99) < 70);
        Shift_Amount_I = 6'($urandom_range(0, 40));
        if ($urandom_range(0, 99) < 2) begin
          Start_I = 1;
          Start_Address_I = AW'($urandom());
          End_Address_I = Start_Address_I + AW'($urandom_range(0, 20));
        end
        step();
        Start_I = 0;
      end
      idle_inputs();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
